// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the junction controller and its helpers.
// Lamp vectors are {red, amber, green}, matching a single traffic head.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_ALL_RED   = 3'd0,
    ST_RED_AMBER = 3'd1,
    ST_GREEN     = 3'd2,
    ST_AMBER     = 3'd3,
    ST_WALK      = 3'd4
  } state_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  localparam logic [2:0] LAMP_RED       = 3'b100;
  localparam logic [2:0] LAMP_RED_AMBER = 3'b110;
  localparam logic [2:0] LAMP_GREEN     = 3'b001;
  localparam logic [2:0] LAMP_AMBER     = 3'b010;

  // Lamp shown by the head currently being served; the idle head is always red.
  function automatic logic [2:0] active_lamp(input state_t s);
    case (s)
      ST_RED_AMBER: active_lamp = LAMP_RED_AMBER;
      ST_GREEN:     active_lamp = LAMP_GREEN;
      ST_AMBER:     active_lamp = LAMP_AMBER;
      default:      active_lamp = LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that flags the last cycle of a phase.
// A phase loaded with T-1 therefore lasts exactly T cycles.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/junction_controller.sv
// Two-road junction sequencer with a pedestrian all-walk phase.
// Outputs decode from registered state only, so they switch on the state edge.
module junction_controller
  import traffic_pkg::*;
#(
  parameter int T_RED_AMBER = 2,
  parameter int T_GREEN     = 8,
  parameter int T_AMBER     = 2,
  parameter int T_ALL_RED   = 1,
  parameter int T_WALK      = 6,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  output logic [2:0] ns_lamps,
  output logic [2:0] ew_lamps,
  output logic       walk,
  output logic       ped_ack,
  output logic       ped_pending
);

  localparam logic [CNT_W-1:0] LD_RED_AMBER = CNT_W'(T_RED_AMBER - 1);
  localparam logic [CNT_W-1:0] LD_GREEN     = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_AMBER     = CNT_W'(T_AMBER - 1);
  localparam logic [CNT_W-1:0] LD_ALL_RED   = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] LD_WALK      = CNT_W'(T_WALK - 1);

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic             pending_q;
  logic             ack_q;
  logic             done;
  logic             enter_walk;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (done)
  );

  // A request arriving on the WALK-entry edge survives the clear (set wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ALL_RED;
      dir_q     <= DIR_EW;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      ack_q     <= enter_walk;
      if (ped_req)
        pending_q <= 1'b1;
      else if (enter_walk)
        pending_q <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    enter_walk = 1'b0;
    if (done) begin
      case (state_q)
        ST_RED_AMBER: state_d = ST_GREEN;
        ST_GREEN:     state_d = ST_AMBER;
        ST_AMBER:     state_d = ST_ALL_RED;
        ST_ALL_RED: begin
          if (pending_q) begin
            state_d    = ST_WALK;
            enter_walk = 1'b1;
          end else begin
            state_d = ST_RED_AMBER;
            dir_d   = dir_t'(~dir_q);
          end
        end
        ST_WALK: begin
          state_d = ST_RED_AMBER;
          dir_d   = dir_t'(~dir_q);
        end
        default:      state_d = ST_ALL_RED;
      endcase
    end
  end

  // Every expiry is a state change, so the timer reloads on done or reset.
  always_comb begin
    timer_load = rst | done;
    case (state_d)
      ST_RED_AMBER: timer_val = LD_RED_AMBER;
      ST_GREEN:     timer_val = LD_GREEN;
      ST_AMBER:     timer_val = LD_AMBER;
      ST_WALK:      timer_val = LD_WALK;
      default:      timer_val = LD_ALL_RED;
    endcase
    if (rst)
      timer_val = LD_ALL_RED;
  end

  always_comb begin
    ns_lamps = LAMP_RED;
    ew_lamps = LAMP_RED;
    walk     = 1'b0;
    case (state_q)
      ST_WALK:    walk = 1'b1;
      ST_ALL_RED: walk = 1'b0;
      default: begin
        if (dir_q == DIR_NS)
          ns_lamps = active_lamp(state_q);
        else
          ew_lamps = active_lamp(state_q);
      end
    endcase
  end

  assign ped_ack     = ack_q;
  assign ped_pending = pending_q;

endmodule

// File: tb/tb_junction_controller.sv
// Scoreboard bench: directed segments push hand-computed per-cycle outputs,
// a negedge monitor pops and compares them and checks safety every cycle.
module tb_junction_controller;

  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] RA = 3'b110;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] A  = 3'b010;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic       ack;
    logic       pend;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_req = 1'b0;
  logic       ped_req1 = 1'b0;
  logic [2:0] ns0, ew0, ns1, ew1;
  logic       walk0, ack0, pend0, walk1, ack1, pend1;
  logic       prev_ack0 = 1'b0;
  logic       prev_ack1 = 1'b0;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  junction_controller dut0 (
    .clk(clk), .rst(rst), .ped_req(ped_req),
    .ns_lamps(ns0), .ew_lamps(ew0), .walk(walk0),
    .ped_ack(ack0), .ped_pending(pend0)
  );

  junction_controller #(
    .T_RED_AMBER(1), .T_GREEN(1), .T_AMBER(1), .T_ALL_RED(1), .T_WALK(1), .CNT_W(4)
  ) dut1 (
    .clk(clk), .rst(rst), .ped_req(ped_req1),
    .ns_lamps(ns1), .ew_lamps(ew1), .walk(walk1),
    .ped_ack(ack1), .ped_pending(pend1)
  );

  task automatic pushN(input int sel, input logic [2:0] ns, input logic [2:0] ew,
                       input logic w, input logic ack, input logic pend, input int n);
    exp_t e;
    e = '{ns: ns, ew: ew, walk: w, ack: ack, pend: pend};
    for (int i = 0; i < n; i++) begin
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
  endtask

  // Drives one value per cycle from the masks, starting #1 after an edge.
  task automatic applyStimulus(input int n, input logic [63:0] req_mask,
                               input logic [63:0] req1_mask, input logic [63:0] rst_mask);
    for (int i = 0; i < n; i++) begin
      ped_req  = req_mask[i];
      ped_req1 = req1_mask[i];
      rst      = rst_mask[i];
      @(posedge clk);
      #1;
    end
    ped_req  = 1'b0;
    ped_req1 = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic checkOutput(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got ns=%b ew=%b walk=%b ack=%b pend=%b, expected ns=%b ew=%b walk=%b ack=%b pend=%b",
               name, $time, act.ns, act.ew, act.walk, act.ack, act.pend,
               exp.ns, exp.ew, exp.walk, exp.ack, exp.pend);
    end
  endtask

  task automatic checkSafety(input string name, input logic [2:0] ns, input logic [2:0] ew,
                             input logic w, input logic ack, input logic prev_ack);
    checks++;
    if ((ns[0] && ew[0]) || (w && !(ns == R && ew == R)) || (ack && prev_ack)) begin
      errors++;
      $display("[TB] FAIL %s safety at %0t: ns=%b ew=%b walk=%b ack=%b prev_ack=%b",
               name, $time, ns, ew, w, ack, prev_ack);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checkOutput("dut0", {ns0, ew0, walk0, ack0, pend0}, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checkOutput("dut1", {ns1, ew1, walk1, ack1, pend1}, e);
    end
    checkSafety("dut0", ns0, ew0, walk0, ack0, prev_ack0);
    checkSafety("dut1", ns1, ew1, walk1, ack1, prev_ack1);
    prev_ack0 = ack0;
    prev_ack1 = ack1;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Segment 1: free run after reset; dut1 gets a request in its second NS phase.
    pushN(0, R, R, 0, 0, 0, 1);
    pushN(0, RA, R, 0, 0, 0, 2); pushN(0, G, R, 0, 0, 0, 8);
    pushN(0, A, R, 0, 0, 0, 2);  pushN(0, R, R, 0, 0, 0, 1);
    pushN(0, R, RA, 0, 0, 0, 2); pushN(0, R, G, 0, 0, 0, 8);
    pushN(0, R, A, 0, 0, 0, 2);  pushN(0, R, R, 0, 0, 0, 1);
    pushN(1, R, R, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      pushN(1, RA, R, 0, 0, 0, 1); pushN(1, G, R, 0, 0, 0, 1);
      pushN(1, A, R, 0, 0, 0, 1);  pushN(1, R, R, 0, 0, 0, 1);
      if (k == 0) begin
        pushN(1, R, RA, 0, 0, 0, 1); pushN(1, R, G, 0, 0, 0, 1);
        pushN(1, R, A, 0, 0, 0, 1);  pushN(1, R, R, 0, 0, 0, 1);
      end
    end
    q1[10].pend = 1'b1;
    q1[11].pend = 1'b1;
    q1[12].pend = 1'b1;
    pushN(1, R, R, 1, 1, 0, 1);
    pushN(1, R, RA, 0, 0, 0, 1); pushN(1, R, G, 0, 0, 0, 1);
    pushN(1, R, A, 0, 0, 0, 1);  pushN(1, R, R, 0, 0, 0, 1);
    pushN(1, RA, R, 0, 0, 0, 1); pushN(1, G, R, 0, 0, 0, 1);
    pushN(1, A, R, 0, 0, 0, 1);  pushN(1, R, R, 0, 0, 0, 1);
    pushN(1, R, RA, 0, 0, 0, 1); pushN(1, R, G, 0, 0, 0, 1);
    pushN(1, R, A, 0, 0, 0, 1);  pushN(1, R, R, 0, 0, 0, 1);
    pushN(1, RA, R, 0, 0, 0, 1);
    applyStimulus(27, 64'd0, 64'd1 << 9, 64'd0);

    // Segment 2: one-cycle request in the third NS green cycle.
    pushN(0, RA, R, 0, 0, 0, 2); pushN(0, G, R, 0, 0, 0, 3);
    pushN(0, G, R, 0, 0, 1, 5);  pushN(0, A, R, 0, 0, 1, 2);
    pushN(0, R, R, 0, 0, 1, 1);
    pushN(0, R, R, 1, 1, 0, 1);  pushN(0, R, R, 1, 0, 0, 5);
    pushN(0, R, RA, 0, 0, 0, 2); pushN(0, R, G, 0, 0, 0, 8);
    pushN(0, R, A, 0, 0, 0, 2);  pushN(0, R, R, 0, 0, 0, 1);
    applyStimulus(32, 64'd1 << 4, 64'd0, 64'd0);

    // Segment 3: request held across the WALK-entry edge yields a second walk.
    pushN(0, RA, R, 0, 0, 0, 2); pushN(0, G, R, 0, 0, 0, 3);
    pushN(0, G, R, 0, 0, 1, 5);  pushN(0, A, R, 0, 0, 1, 2);
    pushN(0, R, R, 0, 0, 1, 1);
    pushN(0, R, R, 1, 1, 1, 1);  pushN(0, R, R, 1, 0, 1, 5);
    pushN(0, R, RA, 0, 0, 1, 2); pushN(0, R, G, 0, 0, 1, 8);
    pushN(0, R, A, 0, 0, 1, 2);  pushN(0, R, R, 0, 0, 1, 1);
    pushN(0, R, R, 1, 1, 0, 1);  pushN(0, R, R, 1, 0, 0, 5);
    applyStimulus(38, ((64'd1 << 9) - 64'd1) << 4, 64'd0, 64'd0);

    // Segment 4: reset during EW green with a request pending and one coincident.
    pushN(0, RA, R, 0, 0, 0, 2); pushN(0, G, R, 0, 0, 0, 8);
    pushN(0, A, R, 0, 0, 0, 2);  pushN(0, R, R, 0, 0, 0, 1);
    pushN(0, R, RA, 0, 0, 0, 2); pushN(0, R, G, 0, 0, 0, 1);
    pushN(0, R, G, 0, 0, 1, 2);  pushN(0, R, R, 0, 0, 0, 1);
    pushN(0, RA, R, 0, 0, 0, 2);
    applyStimulus(21, (64'd1 << 15) | (64'd1 << 17), 64'd0, 64'd1 << 17);

    // Random request traffic; only the per-cycle safety checks apply here.
    for (int i = 0; i < 10000; i++) begin
      ped_req  = ($urandom_range(0, 7) == 0);
      ped_req1 = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end
    ped_req  = 1'b0;
    ped_req1 = 1'b0;
    @(posedge clk);
    #1;

    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0",
               q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
